// File: rtl/wheel_sensor_conditioner.sv
// Reed-switch front end for the cycle computer sensors slave: synchronise and
// debounce nFork/nCrank, then timestamp each closure as period/count/new/stopped.
module wheel_sensor_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PERIOD_WIDTH    = 24,
    parameter int COUNT_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES  = 16000000
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    nFork,
    input  logic                    nCrank,
    input  logic                    fork_clr,
    input  logic                    crank_clr,
    input  logic                    count_clr,
    output logic [PERIOD_WIDTH-1:0] fork_period,
    output logic [COUNT_WIDTH-1:0]  fork_count,
    output logic                    fork_new,
    output logic                    fork_stopped,
    output logic [PERIOD_WIDTH-1:0] crank_period,
    output logic [COUNT_WIDTH-1:0]  crank_count,
    output logic                    crank_new,
    output logic                    crank_stopped
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PERIOD_WIDTH-1:0] P_MAX = '1;
    localparam logic [PERIOD_WIDTH-1:0] P_TIMEOUT = PERIOD_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] new_clr;

    assign raw     = {nCrank, nFork};
    assign new_clr = {crank_clr, fork_clr};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SYNC_STAGES-1:0]  sync;
        logic                    synced;
        logic                    level;
        logic                    db_done;
        logic                    closure;
        logic [DW-1:0]           db_cnt;
        logic [PERIOD_WIDTH-1:0] p_cnt;
        logic [PERIOD_WIDTH-1:0] p_next;
        logic [PERIOD_WIDTH-1:0] period;
        logic [COUNT_WIDTH-1:0]  count;
        logic                    fresh;
        logic                    stopped;

        assign synced  = sync[SYNC_STAGES-1];
        assign db_done = (synced != level) && (db_cnt == DB_LAST);
        // Only the released->closed transition of the debounced level counts
        assign closure = db_done && level;
        assign p_next  = (p_cnt == P_MAX) ? P_MAX : p_cnt + PERIOD_WIDTH'(1);

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                sync   <= '1;
                level  <= 1'b1;
                db_cnt <= '0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], raw[c]};
                if (synced == level) begin
                    db_cnt <= '0;
                end else if (db_done) begin
                    level  <= ~level;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
        end

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                p_cnt   <= '0;
                period  <= '0;
                count   <= '0;
                fresh   <= 1'b0;
                stopped <= 1'b1;
            end else begin
                p_cnt <= closure ? '0 : p_next;
                if (closure) begin
                    stopped <= 1'b0;
                    period  <= stopped ? '0 : p_next;
                end else if (p_cnt == P_TIMEOUT) begin
                    stopped <= 1'b1;
                end
                // A trip reset landing on a closure still counts that closure
                if (closure) begin
                    count <= count_clr ? COUNT_WIDTH'(1) : count + COUNT_WIDTH'(1);
                end else if (count_clr) begin
                    count <= '0;
                end
                fresh <= closure | (fresh & ~new_clr[c]);
            end
        end
    end

    assign fork_period   = g_ch[0].period;
    assign fork_count    = g_ch[0].count;
    assign fork_new      = g_ch[0].fresh;
    assign fork_stopped  = g_ch[0].stopped;
    assign crank_period  = g_ch[1].period;
    assign crank_count   = g_ch[1].count;
    assign crank_new     = g_ch[1].fresh;
    assign crank_stopped = g_ch[1].stopped;

endmodule
